// File: rtl/kmeans_pkg.sv
// Shared K-means types: coordinate geometry, point record, seed-controller state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kmeans_pkg;

    localparam int COORD_W = 9;
    localparam int MAX_K   = 8;
    localparam int IDX_W   = $clog2(MAX_K);
    // Wide enough to hold MAX_K itself (count of written points) and a retry count up to 15.
    localparam int CNT_W   = 4;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RND,
        ST_CHECK,
        ST_WRITE,
        ST_DONE,
        ST_FAIL
    } seed_state_e;

    // Unsigned inclusive upper-bound test. The coordinate is zero-extended by one bit so that a
    // limit equal to the full coordinate range still yields a plain (never trivially folded) compare.
    function automatic logic coord_in_range(input logic [COORD_W-1:0] v, input int lim);
        return {1'b0, v} <= (COORD_W+1)'(lim);
    endfunction

endpackage

// File: rtl/seed_point_buf.sv
// Point buffer holding the centroids accepted so far in the current seeding run.
// Latency: write lands on the clock edge; read port is combinational from rd_j.
// Backpressure: none; the controller writes at most one point per cycle.
module seed_point_buf
    import kmeans_pkg::*;
(
    input  logic               SeedCtrl_clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   idx,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [IDX_W-1:0]   rd_j,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y
);

    // Contents are only meaningful below the controller's point count, so no reset is needed.
    point_t mem [MAX_K];

    // Single write port.
    always_ff @(posedge SeedCtrl_clk) begin
        if (we) begin
            mem[idx] <= {x, y};
        end
    end

    assign rd_x = mem[rd_j].x;
    assign rd_y = mem[rd_j].y;

endmodule

// File: rtl/centroid_seed_ctrl.sv
// Sequences random initial-centroid generation: request sample, range/duplicate check, write.
// Latency: per accepted point 1 capture + max(1,cnt) check + 1 write cycle; all outputs registered.
// Backpressure: stalls in WAIT_RND with rnd_req high until the random source presents rnd_valid.
module centroid_seed_ctrl
    import kmeans_pkg::*;
#(
    parameter int X_MAX     = 511,
    parameter int Y_MAX     = 511,
    parameter int MAX_RETRY = 15
) (
    input  logic               SeedCtrl_clk,
    input  logic               SeedCtrl_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   k_in,
    input  logic               rnd_valid,
    input  logic [COORD_W-1:0] rnd_x,
    input  logic [COORD_W-1:0] rnd_y,
    output logic               rnd_req,
    output logic               cent_we,
    output logic [IDX_W-1:0]   cent_idx,
    output logic [COORD_W-1:0] cent_x,
    output logic [COORD_W-1:0] cent_y,
    output logic [CNT_W-1:0]   k_out,
    output logic               busy,
    output logic               done,
    output logic               err
);

    seed_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   retry_q, retry_d;
    logic [IDX_W-1:0]   j_q, j_d;
    logic [CNT_W-1:0]   k_d;
    point_t             smp_q, smp_d;
    logic [IDX_W-1:0]   cent_idx_d;
    logic [COORD_W-1:0] cent_x_d;
    logic [COORD_W-1:0] cent_y_d;
    logic               reject;
    logic               range_ok;
    logic               buf_we;
    logic [COORD_W-1:0] buf_x;
    logic [COORD_W-1:0] buf_y;

    assign range_ok = coord_in_range(smp_q.x, X_MAX) && coord_in_range(smp_q.y, Y_MAX);

    // The buffer commits during WRITE; an abort in that same cycle discards the point.
    assign buf_we = (state_q == ST_WRITE) && !abort;

    seed_point_buf u_buf (
        .SeedCtrl_clk (SeedCtrl_clk),
        .we           (buf_we),
        .idx          (cnt_q[IDX_W-1:0]),
        .x            (smp_q.x),
        .y            (smp_q.y),
        .rd_j         (j_q),
        .rd_x         (buf_x),
        .rd_y         (buf_y)
    );

    // State register.
    always_ff @(posedge SeedCtrl_clk or negedge SeedCtrl_rst) begin
        if (!SeedCtrl_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-datapath decode; abort overrides everything, including start.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        j_d        = j_q;
        k_d        = k_out;
        smp_d      = smp_q;
        cent_idx_d = cent_idx;
        cent_x_d   = cent_x;
        cent_y_d   = cent_y;
        reject     = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        if (k_in == '0 || k_in > CNT_W'(MAX_K)) begin
                            state_d = ST_FAIL;
                        end else begin
                            k_d     = k_in;
                            cnt_d   = '0;
                            retry_d = '0;
                            state_d = ST_WAIT_RND;
                        end
                    end
                end
                ST_WAIT_RND: begin
                    // rnd_req is the registered copy of "in WAIT_RND", so the handshake is qualified by it.
                    if (rnd_valid && rnd_req) begin
                        smp_d   = '{x: rnd_x, y: rnd_y};
                        j_d     = '0;
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (j_q == '0 && !range_ok) begin
                        reject = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = ST_WRITE;
                    end else if (smp_q.x == buf_x && smp_q.y == buf_y) begin
                        reject = 1'b1;
                    end else if (CNT_W'(j_q) == cnt_q - CNT_W'(1)) begin
                        state_d = ST_WRITE;
                    end else begin
                        j_d = j_q + IDX_W'(1);
                    end

                    if (reject) begin
                        if (retry_q == CNT_W'(MAX_RETRY - 1)) begin
                            state_d = ST_FAIL;
                        end else begin
                            retry_d = retry_q + CNT_W'(1);
                            state_d = ST_WAIT_RND;
                        end
                    end
                end
                ST_WRITE: begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    retry_d = '0;
                    state_d = (cnt_q + CNT_W'(1) == k_out) ? ST_DONE : ST_WAIT_RND;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // The write payload is launched on entry to WRITE so it is registered alongside cent_we.
        if (state_d == ST_WRITE) begin
            cent_idx_d = cnt_q[IDX_W-1:0];
            cent_x_d   = smp_q.x;
            cent_y_d   = smp_q.y;
        end
    end

    // Datapath and output registers; the status flags are registered decodes of the next state.
    always_ff @(posedge SeedCtrl_clk or negedge SeedCtrl_rst) begin
        if (!SeedCtrl_rst) begin
            cnt_q    <= '0;
            retry_q  <= '0;
            j_q      <= '0;
            smp_q    <= '0;
            k_out    <= '0;
            cent_idx <= '0;
            cent_x   <= '0;
            cent_y   <= '0;
            rnd_req  <= 1'b0;
            cent_we  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            j_q      <= j_d;
            smp_q    <= smp_d;
            k_out    <= k_d;
            cent_idx <= cent_idx_d;
            cent_x   <= cent_x_d;
            cent_y   <= cent_y_d;
            rnd_req  <= (state_d == ST_WAIT_RND);
            cent_we  <= (state_d == ST_WRITE);
            busy     <= (state_d == ST_WAIT_RND) || (state_d == ST_CHECK) || (state_d == ST_WRITE);
            done     <= (state_d == ST_DONE);
            err      <= (state_d == ST_FAIL);
        end
    end

endmodule
